// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, LSB first,
// start/busy/done handshake, result held until the next accepted start.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    assign x        = a_sh[0];
    assign y        = b_sh[0];
    assign d        = x ^ y ^ br;
    assign br_next  = (~x & y) | (~(x ^ y) & br);
    assign res_next = {d, res_sh[WIDTH-1:1]};

    // diff/bout are written only on the final RUN edge so partial results never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        br       <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    if (cnt == LAST) begin
                        bus.diff <= res_next;
                        bus.bout <= br_next;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8: directed table,
// handshake corner sequences, and randomized ops against an arithmetic model.
module tb_serial_subtractor;
    logic       clk;
    logic       rst;
    logic       startReq;
    logic       sel8;
    logic [7:0] ain;
    logic [7:0] bin;

    logic       curBusy;
    logic       curDone;
    logic [7:0] curDiff;
    logic       curBout;

    int compared;
    int mismatched;

    logic [7:0] prevDiff [2];
    logic       prevBout [2];

    typedef struct {
        int         w;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs [9];

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    assign bus4.start = startReq & ~sel8;
    assign bus4.a     = ain[3:0];
    assign bus4.b     = bin[3:0];
    assign bus8.start = startReq & sel8;
    assign bus8.a     = ain;
    assign bus8.b     = bin;

    always_comb begin
        curBusy = sel8 ? bus8.busy : bus4.busy;
        curDone = sel8 ? bus8.done : bus4.done;
        curDiff = sel8 ? bus8.diff : {4'b0000, bus4.diff};
        curBout = sel8 ? bus8.bout : bus4.bout;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request, then follow the operation to its done pulse (bounded).
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit junk,
                                 input logic [7:0] prevD, input logic prevB,
                                 output logic [7:0] d, output logic bo,
                                 output int busyCnt, output int lat,
                                 output bit overlap, output bit unstable);
        ain      = av;
        bin      = bv;
        startReq = 1'b1;
        @(posedge clk);
        #1;
        startReq = 1'b0;
        ain      = 8'($urandom);
        bin      = 8'($urandom);
        busyCnt  = 0;
        lat      = 0;
        overlap  = 1'b0;
        unstable = 1'b0;
        while (!curDone && lat < 40) begin
            if (curBusy) busyCnt++;
            if (curDiff !== prevD || curBout !== prevB) unstable = 1'b1;
            if (junk) begin
                startReq = 1'($urandom_range(0, 1));
                ain      = 8'($urandom);
                bin      = 8'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (curBusy && curDone) overlap = 1'b1;
        end
        startReq = 1'b0;
        d  = curDiff;
        bo = curBout;
    endtask

    task automatic runOp(input string tag, input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input bit junk);
        int         idx;
        logic [7:0] d;
        logic       bo;
        int         busyCnt;
        int         lat;
        bit         overlap;
        bit         unstable;
        idx  = (w == 8) ? 1 : 0;
        sel8 = (w == 8);
        applyStimulus(av, bv, junk, prevDiff[idx], prevBout[idx], d, bo, busyCnt, lat, overlap, unstable);
        checkOutput({tag, "_diff"}, 32'(d), 32'(ed));
        checkOutput({tag, "_bout"}, 32'(bo), 32'(eb));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(w));
        checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(w));
        checkOutput({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        checkOutput({tag, "_no_partial"}, 32'(unstable), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_one_cycle"}, 32'(curDone), 32'd0);
        prevDiff[idx] = ed;
        prevBout[idx] = eb;
    endtask

    initial begin
        int doneCnt;
        int cyc;
        int k;
        int nxt;
        int doneCyc [3];
        logic [7:0] gotD [3];
        logic       gotB [3];
        logic [7:0] opA [3];
        logic [7:0] opB [3];
        logic [7:0] capD;
        logic       capB;

        compared   = 0;
        mismatched = 0;
        startReq   = 1'b0;
        sel8       = 1'b0;
        ain        = '0;
        bin        = '0;
        prevDiff   = '{8'd0, 8'd0};
        prevBout   = '{1'b0, 1'b0};

        vecs[0] = '{4, 8'd9,   8'd3,   8'd6,   1'b0};
        vecs[1] = '{4, 8'd3,   8'd9,   8'd10,  1'b1};
        vecs[2] = '{4, 8'd0,   8'd1,   8'd15,  1'b1};
        vecs[3] = '{4, 8'd0,   8'd0,   8'd0,   1'b0};
        vecs[4] = '{4, 8'd15,  8'd0,   8'd15,  1'b0};
        vecs[5] = '{8, 8'd200, 8'd55,  8'd145, 1'b0};
        vecs[6] = '{8, 8'd55,  8'd200, 8'd111, 1'b1};
        vecs[7] = '{8, 8'd0,   8'd255, 8'd1,   1'b1};
        vecs[8] = '{8, 8'd255, 8'd255, 8'd0,   1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy4", 32'(bus4.busy), 32'd0);
        checkOutput("reset_done4", 32'(bus4.done), 32'd0);
        checkOutput("reset_diff4", 32'(bus4.diff), 32'd0);
        checkOutput("reset_bout4", 32'(bus4.bout), 32'd0);
        checkOutput("reset_busy8", 32'(bus8.busy), 32'd0);
        checkOutput("reset_diff8", 32'(bus8.diff), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 9; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, 1'b0);
        end

        // A second start two cycles into RUN must be dropped, not queued.
        $display("[TB] ignored restart");
        sel8     = 1'b0;
        ain      = 8'd5;
        bin      = 8'd2;
        startReq = 1'b1;
        @(posedge clk);
        #1;
        startReq = 1'b0;
        @(posedge clk);
        #1;
        ain      = 8'd1;
        bin      = 8'd7;
        startReq = 1'b1;
        @(posedge clk);
        #1;
        startReq = 1'b0;
        doneCnt  = 0;
        capD     = 8'hFF;
        capB     = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (curDone) begin
                doneCnt++;
                capD = curDiff;
                capB = curBout;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("restart_done_count", 32'(doneCnt), 32'd1);
        checkOutput("restart_diff", 32'(capD), 32'd3);
        checkOutput("restart_bout", 32'(capB), 32'd0);
        checkOutput("restart_idle_after", 32'(curBusy), 32'd0);
        prevDiff[0] = 8'd3;
        prevBout[0] = 1'b0;

        // Reset two cycles into RUN: outputs clear at once and no done follows.
        $display("[TB] reset mid-run");
        ain      = 8'd12;
        bin      = 8'd4;
        startReq = 1'b1;
        @(posedge clk);
        #1;
        startReq = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(bus4.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus4.done), 32'd0);
        checkOutput("midrst_diff4", 32'(bus4.diff), 32'd0);
        checkOutput("midrst_bout4", 32'(bus4.bout), 32'd0);
        checkOutput("midrst_diff8", 32'(bus8.diff), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        doneCnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (curDone || curBusy) doneCnt++;
        end
        checkOutput("midrst_no_done", 32'(doneCnt), 32'd0);
        prevDiff = '{8'd0, 8'd0};
        prevBout = '{1'b0, 1'b0};
        runOp("after_rst", 4, 8'd12, 8'd4, 8'd8, 1'b0, 1'b0);

        // Start held high: one op every WIDTH+2 cycles, each with its own operands.
        $display("[TB] back-to-back WIDTH=8");
        opA  = '{8'd200, 8'd55, 8'd255};
        opB  = '{8'd55, 8'd200, 8'd255};
        sel8 = 1'b1;
        ain  = opA[0];
        bin  = opB[0];
        startReq = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        k   = 0;
        doneCyc = '{0, 0, 0};
        gotD = '{8'd0, 8'd0, 8'd0};
        gotB = '{1'b0, 1'b0, 1'b0};
        while (k < 3 && cyc < 60) begin
            nxt = cyc / 10 + 1;
            if (nxt < 3) begin
                ain = opA[nxt];
                bin = opB[nxt];
            end else begin
                startReq = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (curDone) begin
                doneCyc[k] = cyc;
                gotD[k]    = curDiff;
                gotB[k]    = curBout;
                k++;
            end
        end
        startReq = 1'b0;
        checkOutput("b2b_done_count", 32'(k), 32'd3);
        checkOutput("b2b_first_done", 32'(doneCyc[0]), 32'd8);
        checkOutput("b2b_period1", 32'(doneCyc[1] - doneCyc[0]), 32'd10);
        checkOutput("b2b_period2", 32'(doneCyc[2] - doneCyc[1]), 32'd10);
        checkOutput("b2b_diff0", 32'(gotD[0]), 32'd145);
        checkOutput("b2b_bout0", 32'(gotB[0]), 32'd0);
        checkOutput("b2b_diff1", 32'(gotD[1]), 32'd111);
        checkOutput("b2b_bout1", 32'(gotB[1]), 32'd1);
        checkOutput("b2b_diff2", 32'(gotD[2]), 32'd0);
        checkOutput("b2b_bout2", 32'(gotB[2]), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        prevDiff[1] = 8'd0;
        prevBout[1] = 1'b0;

        $display("[TB] randomized");
        for (int wsel = 0; wsel < 2; wsel++) begin
            int w;
            int mask;
            w    = (wsel == 0) ? 4 : 8;
            mask = (1 << w) - 1;
            for (int n = 0; n < 1000; n++) begin
                int ra;
                int rb;
                ra = int'($urandom_range(0, mask));
                rb = int'($urandom_range(0, mask));
                runOp($sformatf("rand_w%0d_%0d", w, n), w, 8'(ra), 8'(rb),
                      8'((ra - rb) & mask), (ra < rb), 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It complements the `nadder` ripple-carry adder. It trades W cycles of latency for one-cell area, and uses a start/busy/done handshake so a controller can sequence it. The result is held stable on the outputs until the next accepted start.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `bout`  out  1  final borrow; 1 exactly when unsigned a < unsigned b.

## Operation
- FSM states:
  - IDLE → RUN on `start`=1. The accepting edge copies `a` and `b` into shift registers, clears the borrow register, and clears the bit counter.
  - RUN → RUN while counter < WIDTH-1.
  - RUN → DONE on the edge that processes bit WIDTH-1.
  - DONE → IDLE unconditionally after one cycle.
- Per RUN edge, with `x`=a_sh[0], `y`=b_sh[0], `br`=borrow register:
  - `d = x ^ y ^ br`
  - `br_next = (~x & y) | (~(x ^ y) & br)`
  - `d` shifts into the MSB of the result shift register; a_sh and b_sh shift right by 1; the counter increments.
- On the RUN→DONE edge:
  - the completed result shift register loads `diff`;
  - `br_next` loads `bout`.
- `diff`/`bout` change only on the RUN→DONE edge and on reset. They never show partial values.
- `start` in RUN or DONE is ignored. No queuing; the operands on those cycles have no effect.
- `a`/`b` may change freely after the accepting edge.
- Counter width is clog2(WIDTH). It never wraps past WIDTH-1.

## Timing
- Reset (async assert, takes effect immediately):
  - state=IDLE; `busy`=0, `done`=0, `diff`=0, `bout`=0;
  - shift registers, borrow register and counter all cleared.
- Reset asserted mid-RUN aborts the operation. No `done` pulse follows; outputs read 0.
- Reset release: the first rising edge with `rst`=0 may accept `start`.
- Latency:
  - accepting edge E0, then `busy`=1 from E0 through EW;
  - `done`=1 and the result valid after edge EW;
  - `done` returns to 0 after E(W+1).
- `busy` and `done` are never high in the same cycle.
- Throughput: a new `start` can be accepted at the earliest on edge E(W+2), i.e. one operation every WIDTH+2 cycles.
- `start` held high continuously: operations run back-to-back at that rate. Each uses the operands present on its own accepting edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, a=9, b=3, `start` pulsed one cycle → `busy` high for 4 cycles, then `done` for one cycle; diff=6, bout=0.
- WIDTH=4, a=3, b=9 → diff=0xA, bout=1. Also a=0, b=1 → diff=0xF, bout=1; a=b=0 → diff=0, bout=0.
- WIDTH=4, a=5, b=2, then `start` re-pulsed 2 cycles later with a=1, b=7 → second request ignored; single `done`, diff=3, bout=0.
- WIDTH=4, `rst` asserted two cycles into RUN (a=12, b=4) → outputs 0 immediately and no `done`. A new start after release with a=12, b=4 → diff=8, bout=0.
- WIDTH=8, `start` held high for 3 operations (200-55, 55-200, 255-255) → `done` every 10 cycles; results 145/0, 111/1, 0/0.
- Randomized: 1000 ops at WIDTH=4 and WIDTH=8, compared against `(a-b) mod 2^W` and `a<b`.
